// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, default map constants and region decode helpers for the harvard memory responder
// Ports: none (package). Provides state_t, DEF_* constants, region_hit(), word_index().
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [31:0] DEF_INSTR_BASE  = 32'hBFC00000;
    localparam int unsigned DEF_INSTR_WORDS = 256;
    localparam logic [31:0] DEF_DATA_BASE   = 32'h00000000;
    localparam int unsigned DEF_DATA_WORDS  = 1024;

    // The offset is an unsigned 32-bit difference, so an address below the
    // base wraps to a huge offset and falls outside the region.
    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned words);
        logic [31:0] off;
        off = addr - base;
        return (off[1:0] == 2'b00) && ((off >> 2) < words);
    endfunction

    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off >> 2;
    endfunction

endpackage

// File: rtl/harvard_mem_responder_if.sv
// rtl/harvard_mem_responder_if.sv - harvard CPU instruction/data bus between CPU (master) and memory (slave)
// Signals: instr_address/instr_readdata (fetch), data_address/data_write/data_read/
//          data_writedata/data_readdata (load/store). Reads are combinational.
interface harvard_mem_responder_if;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output instr_address,
        input  instr_readdata,
        output data_address,
        output data_write,
        output data_read,
        output data_writedata,
        input  data_readdata
    );

    modport slave (
        input  instr_address,
        output instr_readdata,
        input  data_address,
        input  data_write,
        input  data_read,
        input  data_writedata,
        output data_readdata
    );
endinterface

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word array with RD_PORTS combinational read ports and one synchronous write port
// Ports: clk; wr_en/wr_addr/wr_data (write at rising edge); rd_addr[i]/rd_data[i] (combinational reads).
module mem_word_array #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned RD_PORTS = 1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [31:0]                  wr_data,
    input  logic [RD_PORTS-1:0][AW-1:0]  rd_addr,
    output logic [RD_PORTS-1:0][31:0]    rd_data
);

    // Contents are deliberately not reset: programs survive a CPU reset.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        assign rd_data[p] = mem[rd_addr[p]];
    end

endmodule

// File: rtl/harvard_mem_responder.sv
// rtl/harvard_mem_responder.sv - memory-side responder: instr ROM + data RAM, preload port, run controller
// Ports: clk, reset (async active-low); init_mem/init_mem_addr/init_valid/init_instr/init_ready (preload);
//        start, cpu_active, clk_enable, halted, cycle_count (run control); addr_fault (sticky);
//        bus (harvard_mem_responder_if.slave: instr_* and data_* CPU bus).
module harvard_mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE  = DEF_INSTR_BASE,
    parameter int unsigned INSTR_WORDS = DEF_INSTR_WORDS,
    parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
    parameter int unsigned DATA_WORDS  = DEF_DATA_WORDS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init_mem,
    input  logic [31:0]                    init_mem_addr,
    input  logic                           init_valid,
    input  logic [31:0]                    init_instr,
    output logic                           init_ready,
    input  logic                           start,
    input  logic                           cpu_active,
    output logic                           clk_enable,
    output logic                           addr_fault,
    output logic                           halted,
    output logic [31:0]                    cycle_count,
    harvard_mem_responder_if.slave         bus
);

    localparam int unsigned IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam int unsigned DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    state_t         state, state_next;
    logic [IAW-1:0] load_ptr;
    logic           prev_active;

    logic           enter_load;
    logic           enter_run;
    logic           preload_we;
    logic           run_active;

    // Region decode for both bus sides
    logic           fetch_hit;
    logic           data_hit;
    logic           data_in_instr;
    logic [IAW-1:0] fetch_idx;
    logic [IAW-1:0] data_instr_idx;
    logic [DAW-1:0] data_idx;

    assign fetch_hit      = region_hit(bus.instr_address, INSTR_BASE, INSTR_WORDS);
    assign data_hit       = region_hit(bus.data_address, DATA_BASE, DATA_WORDS);
    assign data_in_instr  = region_hit(bus.data_address, INSTR_BASE, INSTR_WORDS);
    assign fetch_idx      = IAW'(word_index(bus.instr_address, INSTR_BASE));
    assign data_instr_idx = IAW'(word_index(bus.data_address, INSTR_BASE));
    assign data_idx       = DAW'(word_index(bus.data_address, DATA_BASE));

    // Next-state and strobes
    always_comb begin
        state_next = state;
        enter_load = 1'b0;
        enter_run  = 1'b0;
        preload_we = 1'b0;
        run_active = 1'b0;
        case (state)
            IDLE: begin
                if (init_mem) begin
                    state_next = LOAD;
                    enter_load = 1'b1;
                end else if (start) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            LOAD: begin
                // A beat presented while init_mem falls is still written.
                preload_we = init_valid;
                if (!init_mem) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                run_active = 1'b1;
                if (prev_active && !cpu_active) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (init_mem) begin
                    state_next = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign init_ready = (state == LOAD);
    assign clk_enable = (state == RUN);
    assign halted     = (state == HALT);

    // Bus faults, only meaningful while the CPU is running
    logic fault_now;
    logic data_we;

    assign fault_now = !fetch_hit
                     || (bus.data_read && !(data_hit || data_in_instr))
                     || (bus.data_write && !data_hit)
                     || (bus.data_read && bus.data_write);

    assign data_we = run_active && bus.data_write && !bus.data_read && data_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ptr    <= '0;
            prev_active <= 1'b0;
            addr_fault  <= 1'b0;
            cycle_count <= 32'd0;
        end else begin
            if (enter_load) begin
                load_ptr    <= IAW'(word_index(init_mem_addr, INSTR_BASE));
                addr_fault  <= 1'b0;
                cycle_count <= 32'd0;
            end else if (preload_we) begin
                // Power-of-two depth makes the natural overflow the wrap.
                load_ptr <= load_ptr + IAW'(1);
            end

            if (enter_run) begin
                prev_active <= 1'b0;
            end else if (run_active) begin
                prev_active <= cpu_active;
            end

            // The cycle that samples the falling cpu_active is still counted.
            if (run_active) begin
                cycle_count <= cycle_count + 32'd1;
                if (fault_now) begin
                    addr_fault <= 1'b1;
                end
            end
        end
    end

    // Instruction array: port 0 serves fetch, port 1 serves data-side constant reads
    logic [1:0][IAW-1:0] instr_rd_addr;
    logic [1:0][31:0]    instr_rd_data;

    assign instr_rd_addr[0] = fetch_idx;
    assign instr_rd_addr[1] = data_instr_idx;

    mem_word_array #(
        .DEPTH    (INSTR_WORDS),
        .RD_PORTS (2)
    ) u_instr (
        .clk     (clk),
        .wr_en   (preload_we),
        .wr_addr (load_ptr),
        .wr_data (init_instr),
        .rd_addr (instr_rd_addr),
        .rd_data (instr_rd_data)
    );

    logic [0:0][DAW-1:0] data_rd_addr;
    logic [0:0][31:0]    data_rd_data;

    assign data_rd_addr[0] = data_idx;

    mem_word_array #(
        .DEPTH    (DATA_WORDS),
        .RD_PORTS (1)
    ) u_data (
        .clk     (clk),
        .wr_en   (data_we),
        .wr_addr (data_idx),
        .wr_data (bus.data_writedata),
        .rd_addr (data_rd_addr),
        .rd_data (data_rd_data)
    );

    assign bus.instr_readdata = fetch_hit ? instr_rd_data[0] : 32'h0;

    always_comb begin
        bus.data_readdata = 32'h0;
        if (data_hit) begin
            bus.data_readdata = data_rd_data[0];
        end else if (data_in_instr) begin
            bus.data_readdata = instr_rd_data[1];
        end
    end

endmodule

// File: tb/tb_harvard_mem_responder.sv
// tb/tb_harvard_mem_responder.sv - directed self-checking bench for harvard_mem_responder
module tb_harvard_mem_responder;

    logic        clk;
    logic        reset;
    logic        init_mem;
    logic [31:0] init_mem_addr;
    logic        init_valid;
    logic [31:0] init_instr;
    logic        init_ready;
    logic        start;
    logic        cpu_active;
    logic        clk_enable;
    logic        addr_fault;
    logic        halted;
    logic [31:0] cycle_count;

    int n_assert;
    int n_fail;

    harvard_mem_responder_if bus ();

    harvard_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .init_mem      (init_mem),
        .init_mem_addr (init_mem_addr),
        .init_valid    (init_valid),
        .init_instr    (init_instr),
        .init_ready    (init_ready),
        .start         (start),
        .cpu_active    (cpu_active),
        .clk_enable    (clk_enable),
        .addr_fault    (addr_fault),
        .halted        (halted),
        .cycle_count   (cycle_count),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input int n,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] ws [3];
        ws[0] = w0;
        ws[1] = w1;
        ws[2] = w2;
        init_mem      = 1'b1;
        init_mem_addr = addr;
        tick();
        for (int i = 0; i < n; i++) begin
            init_valid = 1'b1;
            init_instr = ws[i];
            if (i == n - 1) init_mem = 1'b0;
            tick();
        end
        init_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset         = 1'b0;
        init_mem      = 1'b0;
        init_mem_addr = 32'h0;
        init_valid    = 1'b0;
        init_instr    = 32'h0;
        start         = 1'b0;
        cpu_active    = 1'b0;
        bus.instr_address  = 32'hBFC00000;
        bus.data_address   = 32'h0;
        bus.data_write     = 1'b0;
        bus.data_read      = 1'b0;
        bus.data_writedata = 32'h0;
        #3;
        check("rst_init_ready", {31'b0, init_ready}, 32'd0);
        check("rst_clk_enable", {31'b0, clk_enable}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_addr_fault", {31'b0, addr_fault}, 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        #9;
        reset = 1'b1;
        tick();

        // Preload three words at the reset vector
        init_mem      = 1'b1;
        init_mem_addr = 32'hBFC00000;
        tick();
        check("load_init_ready", {31'b0, init_ready}, 32'd1);
        init_mem = 1'b0;
        tick();
        preload(32'hBFC00000, 3, 32'h24020005, 32'h00000008, 32'h00000000);
        check("load_done_ready", {31'b0, init_ready}, 32'd0);
        bus.instr_address = 32'hBFC00004;
        #1;
        check("fetch_word1", bus.instr_readdata, 32'h00000008);
        bus.instr_address = 32'hBFC00000;
        #1;
        check("fetch_word0", bus.instr_readdata, 32'h24020005);

        // Preload wrapping past the top of the instruction region
        preload(32'hBFC003FC, 2, 32'h11111111, 32'h22222222, 32'h0);
        bus.instr_address = 32'hBFC003FC;
        #1;
        check("wrap_last", bus.instr_readdata, 32'h11111111);
        bus.instr_address = 32'hBFC00000;
        #1;
        check("wrap_first", bus.instr_readdata, 32'h22222222);
        bus.instr_address = 32'hBFC00004;
        #1;
        check("wrap_keep1", bus.instr_readdata, 32'h00000008);
        bus.instr_address = 32'hBFC00000;

        // Data side read of instruction constants
        bus.data_address = 32'hBFC00004;
        #1;
        check("data_rd_instr", bus.data_readdata, 32'h00000008);

        // Misaligned fetch outside RUN raises no fault
        bus.instr_address = 32'h00000002;
        tick();
        check("idle_no_fault", {31'b0, addr_fault}, 32'd0);
        bus.instr_address = 32'hBFC00000;

        // Run: write then read back
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_clk_enable", {31'b0, clk_enable}, 32'd1);
        bus.data_address   = 32'h10;
        bus.data_write     = 1'b1;
        bus.data_writedata = 32'hDEADBEEF;
        tick();
        bus.data_write = 1'b0;
        bus.data_read  = 1'b1;
        #1;
        check("raw_readback", bus.data_readdata, 32'hDEADBEEF);
        tick();
        check("run_no_fault", {31'b0, addr_fault}, 32'd0);
        bus.data_address = 32'hBFC00004;
        tick();
        check("rd_instr_no_fault", {31'b0, addr_fault}, 32'd0);
        bus.data_read = 1'b0;

        // Write into instruction region faults and leaves the ROM alone
        bus.data_address   = 32'hBFC00000;
        bus.data_write     = 1'b1;
        bus.data_writedata = 32'hCAFEF00D;
        tick();
        bus.data_write = 1'b0;
        check("wr_instr_fault", {31'b0, addr_fault}, 32'd1);
        check("instr_unchanged", bus.instr_readdata, 32'h22222222);

        // Simultaneous read and write faults without writing
        do_reset();
        check("reset_clears_fault", {31'b0, addr_fault}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.data_address   = 32'h10;
        bus.data_read      = 1'b1;
        bus.data_write     = 1'b1;
        bus.data_writedata = 32'h12345678;
        tick();
        bus.data_write = 1'b0;
        check("rw_both_fault", {31'b0, addr_fault}, 32'd1);
        #1;
        check("rw_both_no_write", bus.data_readdata, 32'hDEADBEEF);
        bus.data_read = 1'b0;

        // Misaligned fetch in RUN
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.instr_address = 32'h00000002;
        #1;
        check("fetch_miss_data", bus.instr_readdata, 32'h0);
        tick();
        check("fetch_miss_fault", {31'b0, addr_fault}, 32'd1);
        bus.instr_address = 32'hBFC00000;

        // Halt detection and cycle counting
        do_reset();
        start = 1'b1;
        tick();
        start      = 1'b0;
        cpu_active = 1'b1;
        repeat (10) tick();
        check("run_count10", cycle_count, 32'd10);
        check("run_not_halted", {31'b0, halted}, 32'd0);
        cpu_active = 1'b0;
        tick();
        check("halt_halted", {31'b0, halted}, 32'd1);
        check("halt_clk_enable", {31'b0, clk_enable}, 32'd0);
        check("halt_count", cycle_count, 32'd11);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        check("halt_frozen", cycle_count, 32'd11);
        check("halt_ignores_start", {31'b0, halted}, 32'd1);
        init_mem      = 1'b1;
        init_mem_addr = 32'hBFC00100;
        tick();
        check("halt_to_load_halted", {31'b0, halted}, 32'd0);
        check("halt_to_load_count", cycle_count, 32'd0);
        check("halt_to_load_ready", {31'b0, init_ready}, 32'd1);
        init_mem = 1'b0;
        tick();

        // Reset in the middle of a preload
        init_mem      = 1'b1;
        init_mem_addr = 32'hBFC00010;
        tick();
        init_valid = 1'b1;
        init_instr = 32'hAAAA0001;
        tick();
        init_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midload_rst_ready", {31'b0, init_ready}, 32'd0);
        check("midload_rst_clk_en", {31'b0, clk_enable}, 32'd0);
        check("midload_rst_halted", {31'b0, halted}, 32'd0);
        check("midload_rst_count", cycle_count, 32'd0);
        init_mem = 1'b0;
        reset    = 1'b1;
        tick();
        preload(32'hBFC00010, 1, 32'hBBBB0002, 32'h0, 32'h0);
        bus.instr_address = 32'hBFC00010;
        #1;
        check("reload_restart", bus.instr_readdata, 32'hBBBB0002);
        bus.instr_address = 32'hBFC00000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
